imem_loader: RTL and testbench

//  Writable, parametrised instruction memory for the single-cycle LEGv8 core.
//  - Programs are streamed in byte-wise over a valid/ready port instead of being fixed at elaboration.
//  - Read port stays combinational, so the fetch stage is unchanged.
//  - A load FSM holds the core (cpu_run=0) until a full program is loaded.
//  - Unloaded words read as zero, so stale code is never fetched.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 105 ++++++++++
 tb/tb_imem_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream load port of the instruction memory loader.
// The source drives bytes with valid/last; the loader answers with ready.
interface imem_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       load_last;

    modport master (
        output byte_in,
        output byte_valid,
        output load_last,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        input  load_last,
        output byte_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Writable instruction memory for the single-cycle LEGv8 core: a byte-stream
// loader fills it little-endian and holds the core until a program is in place.
module imem_loader #(
    parameter int N  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  q,
    input  logic          load_start,
    imem_loader_if.slave  stream,
    output logic          cpu_run,
    output logic [AW:0]   word_count,
    output logic          load_err
);

    localparam int BPW   = N / 8;
    localparam int IW    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = AW + 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    typedef logic [N-1:0] word_t;
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        state_q;
    state_t        state_d;
    word_t         mem [DEPTH];
    word_t         shift_q;
    word_t         assembled;
    logic [IW-1:0] byte_idx;
    logic          xfer;
    logic          full;
    logic          start_load;
    logic          word_done;

    assign stream.byte_ready = (state_q == LOAD);
    assign cpu_run           = (state_q == RUN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        xfer       = stream.byte_valid && (state_q == LOAD);
        start_load = load_start && (state_q != LOAD);
        full       = (word_count == FULL);
        assembled  = shift_q | (word_t'(stream.byte_in) << {byte_idx, 3'b000});
        // A word closes on its last byte, or early when the program ends mid-word.
        word_done  = xfer && !full && ((byte_idx == LAST_IDX) || stream.load_last);

        unique case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (xfer && stream.load_last) state_d = RUN;
            RUN:     if (load_start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || start_load) begin
            word_count <= '0;
            load_err   <= 1'b0;
            byte_idx   <= '0;
            shift_q    <= '0;
        end else if (xfer) begin
            if (full) begin
                load_err <= 1'b1;
            end else if (word_done) begin
                word_count <= word_count + CW'(1);
                byte_idx   <= '0;
                shift_q    <= '0;
                if (byte_idx != LAST_IDX) begin
                    load_err <= 1'b1;
                end
            end else begin
                shift_q  <= assembled;
                byte_idx <= byte_idx + IW'(1);
            end
        end
    end

    // NOTE: the array has no reset; word_count masking hides stale contents,
    // which keeps the storage inferable as plain RAM.
    always_ff @(posedge clk) begin
        if (word_done && !reset) begin
            mem[word_count[AW-1:0]] <= assembled;
        end
    end

    assign q = ({1'b0, addr} < word_count) ? mem[addr] : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a 64-word instance for the main scenarios
// and a 4-word instance for overflow.
module tb_imem_loader;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  addr_m = '0;
    logic [1:0]  addr_o = '0;
    logic [31:0] q_m;
    logic [31:0] q_o;
    logic        ls_m = 1'b0;
    logic        ls_o = 1'b0;
    logic        run_m;
    logic        run_o;
    logic [6:0]  wc_m;
    logic [2:0]  wc_o;
    logic        err_m;
    logic        err_o;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb[$];

    imem_loader_if bus_m ();
    imem_loader_if bus_o ();

    imem_loader #(.N(32), .AW(6)) u_main (
        .clk(clk), .reset(reset), .addr(addr_m), .q(q_m), .load_start(ls_m),
        .stream(bus_m), .cpu_run(run_m), .word_count(wc_m), .load_err(err_m)
    );

    imem_loader #(.N(32), .AW(2)) u_ovf (
        .clk(clk), .reset(reset), .addr(addr_o), .q(q_o), .load_start(ls_o),
        .stream(bus_o), .cpu_run(run_o), .word_count(wc_o), .load_err(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input bit ovf);
        @(negedge clk);
        if (ovf) ls_o = 1'b1; else ls_m = 1'b1;
        @(negedge clk);
        ls_o = 1'b0;
        ls_m = 1'b0;
    endtask

    task automatic read_q(input bit ovf, input int a, output logic [31:0] v);
        if (ovf) addr_o = a[1:0]; else addr_m = a[5:0];
        #1;
        v = ovf ? q_o : q_m;
    endtask

    task automatic send_byte(input bit ovf, input logic [7:0] b, input logic last);
        bit acc = 1'b0;
        int n   = 0;
        if (ovf) begin
            bus_o.byte_in = b; bus_o.byte_valid = 1'b1; bus_o.load_last = last;
        end else begin
            bus_m.byte_in = b; bus_m.byte_valid = 1'b1; bus_m.load_last = last;
        end
        while (!acc && n < 16) begin
            acc = ovf ? bus_o.byte_ready : bus_m.byte_ready;
            @(negedge clk);
            n++;
        end
        bus_o.byte_valid = 1'b0; bus_o.load_last = 1'b0;
        bus_m.byte_valid = 1'b0; bus_m.load_last = 1'b0;
        n_checks++;
        if (acc !== 1'b1) $display("FAIL byte_accept: got no acceptance, required acceptance within 16 cycles");
        else n_pass++;
    endtask

    // Streams a program and pushes each word the loader should store.
    task automatic stream(input bit ovf, input logic [7:0] bytes[$], input bit gaps);
        logic [31:0] cur = '0;
        int widx  = 0;
        int depth = ovf ? 4 : 64;
        exp_t e;
        for (int i = 0; i < bytes.size(); i++) begin
            bit last = (i == bytes.size() - 1);
            send_byte(ovf, bytes[i], last);
            cur = cur | ({24'b0, bytes[i]} << (8 * (i % 4)));
            if ((i % 4 == 3) || last) begin
                if (widx < depth) begin
                    e.addr = widx;
                    e.data = cur;
                    sb.push_back(e);
                end
                widx++;
                cur = '0;
            end
            if (gaps && !last) @(negedge clk);
        end
    endtask

    task automatic check_image(input bit ovf, input string tag);
        exp_t e;
        logic [31:0] v;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_q(ovf, e.addr, v);
            n_checks++;
            if (v !== e.data) $display("FAIL %s q@%0d: got %h, required %h", tag, e.addr, v, e.data);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        n_checks++;
        if ({run_m, bus_m.byte_ready, wc_m, err_m} !== 10'b0)
            $display("FAIL reset_main: got run=%b rdy=%b wc=%0d err=%b, required all 0", run_m, bus_m.byte_ready, wc_m, err_m);
        else n_pass++;
        n_checks++;
        if ({run_o, bus_o.byte_ready, wc_o, err_o} !== 6'b0)
            $display("FAIL reset_ovf: got run=%b rdy=%b wc=%0d err=%b, required all 0", run_o, bus_o.byte_ready, wc_o, err_o);
        else n_pass++;
        for (int a = 0; a < 64; a++) begin
            read_q(1'b0, a, v);
            n_checks++;
            if (v !== 32'h0) $display("FAIL reset_q@%0d: got %h, required 00000000", a, v);
            else n_pass++;
        end
    endtask

    task automatic test_load3(input bit gaps, input string tag);
        logic [7:0] prog[$] = '{8'hc5, 8'h03, 8'h1e, 8'h8b, 8'ha5, 8'h00, 8'h04, 8'h8b,
                                8'h42, 8'h00, 8'h02, 8'hcb};
        logic [31:0] v;
        pulse_start(1'b0);
        n_checks++;
        if ({bus_m.byte_ready, run_m} !== 2'b10)
            $display("FAIL %s enter_load: got rdy=%b run=%b, required rdy=1 run=0", tag, bus_m.byte_ready, run_m);
        else n_pass++;
        stream(1'b0, prog, gaps);
        n_checks++;
        if ({run_m, wc_m, err_m} !== {1'b1, 7'd3, 1'b0})
            $display("FAIL %s status: got run=%b wc=%0d err=%b, required run=1 wc=3 err=0", tag, run_m, wc_m, err_m);
        else n_pass++;
        check_image(1'b0, tag);
        read_q(1'b0, 3, v);
        n_checks++;
        if (v !== 32'h0) $display("FAIL %s q@3: got %h, required 00000000", tag, v);
        else n_pass++;
    endtask

    task automatic test_gaps();
        logic [31:0] v;
        do_reset();
        read_q(1'b0, 0, v);
        n_checks++;
        if (v !== 32'h0) $display("FAIL gaps_stale_mask q@0: got %h, required 00000000", v);
        else n_pass++;
        @(negedge clk);
        bus_m.byte_in = 8'hff; bus_m.byte_valid = 1'b1; bus_m.load_last = 1'b1;
        repeat (3) @(negedge clk);
        bus_m.byte_valid = 1'b0; bus_m.load_last = 1'b0;
        n_checks++;
        if ({bus_m.byte_ready, run_m, wc_m, err_m} !== 10'b0)
            $display("FAIL gaps_idle_ignore: got rdy=%b run=%b wc=%0d err=%b, required all 0", bus_m.byte_ready, run_m, wc_m, err_m);
        else n_pass++;
        test_load3(1'b1, "gaps");
    endtask

    task automatic test_partial();
        logic [7:0] prog[$] = '{8'h1f, 8'h00, 8'h00};
        logic [31:0] v;
        pulse_start(1'b0);
        stream(1'b0, prog, 1'b0);
        n_checks++;
        if ({run_m, wc_m, err_m} !== {1'b1, 7'd1, 1'b1})
            $display("FAIL partial status: got run=%b wc=%0d err=%b, required run=1 wc=1 err=1", run_m, wc_m, err_m);
        else n_pass++;
        check_image(1'b0, "partial");
        read_q(1'b0, 1, v);
        n_checks++;
        if (v !== 32'h0) $display("FAIL partial q@1: got %h, required 00000000", v);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] prog[$];
        for (int i = 0; i < 20; i++) prog.push_back(8'(8'h10 + i));
        pulse_start(1'b1);
        stream(1'b1, prog, 1'b0);
        n_checks++;
        if ({run_o, wc_o, err_o} !== {1'b1, 3'd4, 1'b1})
            $display("FAIL overflow status: got run=%b wc=%0d err=%b, required run=1 wc=4 err=1", run_o, wc_o, err_o);
        else n_pass++;
        check_image(1'b1, "overflow");
    endtask

    task automatic test_reload();
        logic [31:0] v;
        exp_t e;
        pulse_start(1'b0);
        read_q(1'b0, 0, v);
        n_checks++;
        if ({run_m, bus_m.byte_ready, wc_m, err_m, v} !== {1'b0, 1'b1, 7'd0, 1'b0, 32'h0})
            $display("FAIL reload_enter: got run=%b rdy=%b wc=%0d err=%b q0=%h, required run=0 rdy=1 wc=0 err=0 q0=0",
                     run_m, bus_m.byte_ready, wc_m, err_m, v);
        else n_pass++;
        send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);
        pulse_start(1'b0);
        send_byte(1'b0, 8'h08, 1'b0);
        send_byte(1'b0, 8'h8b, 1'b1);
        e.addr = 0;
        e.data = 32'h8b080000;
        sb.push_back(e);
        n_checks++;
        if ({run_m, wc_m, err_m} !== {1'b1, 7'd1, 1'b0})
            $display("FAIL reload status: got run=%b wc=%0d err=%b, required run=1 wc=1 err=0", run_m, wc_m, err_m);
        else n_pass++;
        check_image(1'b0, "reload");
        read_q(1'b0, 1, v);
        n_checks++;
        if (v !== 32'h0) $display("FAIL reload q@1: got %h, required 00000000", v);
        else n_pass++;
    endtask

    initial begin
        bus_m.byte_in = '0; bus_m.byte_valid = 1'b0; bus_m.load_last = 1'b0;
        bus_o.byte_in = '0; bus_o.byte_valid = 1'b0; bus_o.load_last = 1'b0;
        test_reset();
        test_load3(1'b0, "load3");
        test_gaps();
        test_partial();
        test_overflow();
        test_reload();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
